// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline stage with two-entry skid buffer and branch redirect
// Optional forwarding outputs enabled by defining EX_MEM_FWD_EN.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module ex_mem_stage #(
    parameter int WIDTH = `WORD_SIZE,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic [WIDTH-1:0] store_data,
    input  logic [REG_W-1:0] dest_reg,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             branch_eq,
    input  logic             branch_ne,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_store_data,
    output logic [REG_W-1:0] out_dest_reg,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
`ifdef EX_MEM_FWD_EN
    output logic             fwd_valid,
    output logic [REG_W-1:0] fwd_reg,
    output logic [WIDTH-1:0] fwd_data,
`endif
    output logic             pc_src,
    output logic [WIDTH-1:0] pc_target
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [WIDTH-1:0] store_data;
        logic [REG_W-1:0] dest_reg;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
    } entry_t;

    state_t           state_q, state_d;
    entry_t           head_q, head_d;
    entry_t           skid_q, skid_d;
    entry_t           in_entry;
    logic             pc_src_q, pc_src_d;
    logic [WIDTH-1:0] pc_target_q, pc_target_d;
    logic             push;
    logic             pop;
    logic             taken;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);

    assign push  = in_valid && in_ready && !flush;
    assign pop   = out_valid && out_ready;
    assign taken = push && ((branch_eq && alu_zero) || (branch_ne && !alu_zero));

    always_comb begin
        in_entry            = '0;
        in_entry.result     = alu_out;
        in_entry.store_data = store_data;
        in_entry.dest_reg   = dest_reg;
        in_entry.reg_write  = reg_write;
        in_entry.mem_read   = mem_read;
        in_entry.mem_write  = mem_write;
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = in_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = in_entry;
                end else if (push) begin
                    skid_d  = in_entry;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over any push/pop; control bits are killed so nothing can retire.
        if (flush) begin
            state_d          = EMPTY;
            head_d.reg_write = 1'b0;
            head_d.mem_read  = 1'b0;
            head_d.mem_write = 1'b0;
            skid_d.reg_write = 1'b0;
            skid_d.mem_read  = 1'b0;
            skid_d.mem_write = 1'b0;
        end
    end

    always_comb begin
        pc_src_d    = taken;
        pc_target_d = taken ? branch_target : pc_target_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            pc_src_q    <= 1'b0;
            pc_target_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            pc_src_q    <= pc_src_d;
            pc_target_q <= pc_target_d;
        end
    end

    // Fields read as zero whenever the buffer holds nothing.
    assign out_result     = out_valid ? head_q.result     : '0;
    assign out_store_data = out_valid ? head_q.store_data : '0;
    assign out_dest_reg   = out_valid ? head_q.dest_reg   : '0;
    assign out_reg_write  = out_valid && head_q.reg_write;
    assign out_mem_read   = out_valid && head_q.mem_read;
    assign out_mem_write  = out_valid && head_q.mem_write;

    assign pc_src    = pc_src_q;
    assign pc_target = pc_target_q;

`ifdef EX_MEM_FWD_EN
    assign fwd_valid = out_valid && out_reg_write && (out_dest_reg != '0);
    assign fwd_reg   = out_dest_reg;
    assign fwd_data  = out_result;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed scoreboard bench for ex_mem_stage

module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic [31:0] store_data;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch_eq;
    logic        branch_ne;
    logic [31:0] branch_target;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_dest_reg;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        pc_src;
    logic [31:0] pc_target;
`ifdef EX_MEM_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
`endif

    int vectors    = 0;
    int miscompares = 0;
    int pops       = 0;
    logic [36:0] sb[$];

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_out       (alu_out),
        .alu_zero      (alu_zero),
        .store_data    (store_data),
        .dest_reg      (dest_reg),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .branch_eq     (branch_eq),
        .branch_ne     (branch_ne),
        .branch_target (branch_target),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_store_data(out_store_data),
        .out_dest_reg  (out_dest_reg),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
`ifdef EX_MEM_FWD_EN
        .fwd_valid     (fwd_valid),
        .fwd_reg       (fwd_reg),
        .fwd_data      (fwd_data),
`endif
        .pc_src        (pc_src),
        .pc_target     (pc_target)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Records acceptance just before the edge, then returns at posedge+1.
    task automatic cycle(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready && !flush;
        if (acc) sb.push_back({alu_out, dest_reg});
        @(posedge clk);
        #1;
    endtask

    // Scoreboard check: every handshake on the MEM side pops the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            logic [36:0] e;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $error("FAIL sb_unexpected observed=%h expected=none", out_result);
            end else begin
                e = sb.pop_front();
                pops++;
                assert ({out_result, out_dest_reg} === e) else begin
                    miscompares++;
                    $error("FAIL sb_entry observed=%h/%0d expected=%h/%0d",
                           out_result, out_dest_reg, e[36:5], e[4:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int tries;
        int pops0;
        reset = 1'b1; in_valid = 1'b0; alu_out = '0; alu_zero = 1'b0; store_data = '0;
        dest_reg = '0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        branch_eq = 1'b0; branch_ne = 1'b0; branch_target = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_result", out_result,    32'd0);
        chk("rst_pc_src",    32'(pc_src),    32'd0);
        chk("rst_pc_target", pc_target,      32'd0);

        // Single entry through an empty buffer.
        in_valid = 1'b1; alu_out = 32'h5; dest_reg = 5'd3; reg_write = 1'b1; out_ready = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        chk("single_valid",   32'(out_valid),    32'd1);
        chk("single_result",  out_result,        32'h5);
        chk("single_dest",    32'(out_dest_reg), 32'd3);
        chk("single_rw",      32'(out_reg_write), 32'd1);
        cycle(acc);
        chk("single_idle",    32'(out_valid),    32'd0);

        // Fill the skid buffer under back-pressure, then drain.
        out_ready = 1'b0; in_valid = 1'b1; alu_out = 32'h11; dest_reg = 5'd1;
        cycle(acc);
        alu_out = 32'h22; dest_reg = 5'd2;
        cycle(acc);
        in_valid = 1'b0;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head",     out_result,    32'h11);
        out_ready = 1'b1;
        cycle(acc);
        chk("drain_head2",   out_result,    32'h22);
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        cycle(acc);
        chk("drain_empty",   32'(out_valid), 32'd0);

        // Branch resolution.
        in_valid = 1'b1; reg_write = 1'b0; dest_reg = 5'd0; alu_out = 32'hA0;
        branch_eq = 1'b1; alu_zero = 1'b1; branch_target = 32'h40;
        cycle(acc);
        in_valid = 1'b0; branch_eq = 1'b0;
        chk("beq_taken_src", 32'(pc_src), 32'd1);
        chk("beq_taken_tgt", pc_target,   32'h40);
        cycle(acc);
        chk("beq_pulse_end", 32'(pc_src), 32'd0);
        chk("beq_tgt_hold",  pc_target,   32'h40);
        in_valid = 1'b1; branch_eq = 1'b1; alu_zero = 1'b0; branch_target = 32'h80; alu_out = 32'hA1;
        cycle(acc);
        in_valid = 1'b0; branch_eq = 1'b0;
        chk("beq_not_taken", 32'(pc_src), 32'd0);
        chk("beq_nt_tgt",    pc_target,   32'h40);
        in_valid = 1'b1; branch_ne = 1'b1; alu_zero = 1'b0; branch_target = 32'hC0; alu_out = 32'hA2;
        cycle(acc);
        in_valid = 1'b0; branch_ne = 1'b0;
        chk("bne_taken_src", 32'(pc_src), 32'd1);
        chk("bne_taken_tgt", pc_target,   32'hC0);
        in_valid = 1'b1; branch_eq = 1'b1; branch_ne = 1'b1; alu_zero = 1'b0;
        branch_target = 32'h100; alu_out = 32'hA3;
        cycle(acc);
        in_valid = 1'b0; branch_eq = 1'b0; branch_ne = 1'b0;
        chk("both_taken_src", 32'(pc_src), 32'd1);
        chk("both_taken_tgt", pc_target,   32'h100);
        cycle(acc);

        // Flush with the buffer full and a taken branch on the input.
        out_ready = 1'b0; in_valid = 1'b1; alu_out = 32'h31; dest_reg = 5'd4; reg_write = 1'b1;
        cycle(acc);
        alu_out = 32'h32;
        cycle(acc);
        chk("pre_flush_full", 32'(in_ready), 32'd0);
        alu_out = 32'h33; flush = 1'b1; branch_eq = 1'b1; alu_zero = 1'b1; branch_target = 32'h200;
        cycle(acc);
        flush = 1'b0; in_valid = 1'b0; branch_eq = 1'b0;
        sb.delete();
        chk("flush_valid",    32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready),  32'd1);
        chk("flush_pc_src",   32'(pc_src),    32'd0);
        chk("flush_result",   out_result,     32'd0);
        chk("flush_tgt_hold", pc_target,      32'h100);
        // Flush while the stage would otherwise accept: branch must not be reported.
        in_valid = 1'b1; flush = 1'b1; branch_eq = 1'b1; alu_zero = 1'b1; branch_target = 32'h300;
        cycle(acc);
        flush = 1'b0; in_valid = 1'b0; branch_eq = 1'b0;
        chk("flush1_valid",  32'(out_valid), 32'd0);
        chk("flush1_pc_src", 32'(pc_src),    32'd0);

        // Burst of 8 with out_ready toggling every cycle.
        pops0 = pops;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; alu_out = 32'(i); dest_reg = 5'(i);
            tries = 0;
            do begin
                out_ready = ~out_ready;
                cycle(acc);
                tries++;
            end while (!acc && tries < 10);
            chk($sformatf("burst_accept_%0d", i), 32'(acc), 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tries = 0;
        while (sb.size() != 0 && tries < 10) begin
            cycle(acc);
            tries++;
        end
        chk("burst_delivered", 32'(pops - pops0), 32'd8);
        chk("burst_sb_empty",  32'(sb.size()),    32'd0);
        chk("burst_end_valid", 32'(out_valid),    32'd0);

`ifdef EX_MEM_FWD_EN
        out_ready = 1'b0; in_valid = 1'b1; alu_out = 32'h77; dest_reg = 5'd0; reg_write = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        chk("fwd_r0_valid", 32'(fwd_valid), 32'd0);
        out_ready = 1'b1;
        cycle(acc);
        out_ready = 1'b0; in_valid = 1'b1; alu_out = 32'h99; dest_reg = 5'd7;
        cycle(acc);
        in_valid = 1'b0;
        chk("fwd_r7_valid", 32'(fwd_valid), 32'd1);
        chk("fwd_r7_reg",   32'(fwd_reg),   32'd7);
        chk("fwd_r7_data",  fwd_data,       32'h99);
        out_ready = 1'b1;
        cycle(acc);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline stage sitting directly downstream of the ALU: captures each executed instruction's ALU result, zero flag, store data and control bits and presents them to the memory stage. It resolves conditional branches from the ALU zero flag and issues a registered redirect to fetch. A two-entry skid buffer decouples a valid/ready handshake toward the ALU stage from back-pressure out of the memory stage. Flush discards all in-flight entries.

## Interface
- `WIDTH`, default `` `WORD_SIZE `` (32): datapath width.
- `REG_W`, default 5: destination register address width.

- `clk` in 1: rising-edge clock, the only clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: EX entry offered.
- `in_ready` out 1: stage accepts the entry this cycle.
- `alu_out` in WIDTH: ALU result.
- `alu_zero` in 1: ALU zero flag.
- `store_data` in WIDTH: rt value for stores.
- `dest_reg` in REG_W: write-back register.
- `reg_write`, `mem_read`, `mem_write` in 1 each: control bits.
- `branch_eq`, `branch_ne` in 1 each: beq/bne decode.
- `branch_target` in WIDTH: computed branch address.
- `flush` in 1: kill all held entries.
- `out_valid` out 1: head entry valid to MEM.
- `out_ready` in 1: MEM consumes head.
- `out_result`, `out_store_data` out WIDTH; `out_dest_reg` out REG_W; `out_reg_write`, `out_mem_read`, `out_mem_write` out 1: head entry fields.
- `pc_src` out 1: one-cycle branch-taken pulse.
- `pc_target` out WIDTH: redirect address, valid when `pc_src`=1.

## Operation
- Push = `in_valid && in_ready && !flush`; pop = `out_valid && out_ready`.
- Occupancy FSM EMPTY/ONE/TWO: EMPTY+push→ONE; ONE+push only→TWO; ONE+pop only→EMPTY; ONE+push+pop→ONE (new entry becomes head); TWO+pop→ONE (skid entry moves to head); TWO ignores `in_valid`.
- `in_ready` = (state != TWO), derived from registered state only; no combinational path from `out_ready`.
- `out_valid` = (state != EMPTY); all `out_*` fields driven from the head entry; when EMPTY, fields are zero.
- Entries leave in order of acceptance; no reordering, no field modification.
- Branch taken = push && ((`branch_eq` && `alu_zero`) || (`branch_ne` && !`alu_zero`)); registered into `pc_src`/`pc_target` on that edge. Both bits set: treat as beq|bne, i.e. always taken.
- `flush` (sync): next state EMPTY, both entries' control bits cleared, `pc_src` 0 next cycle; same-cycle input is dropped and its branch is not reported. Flush overrides push and pop.
- `reset`: same effect as flush plus all data registers cleared.

## Timing
- Reset values: `out_valid`=0, `in_ready`=1 (state EMPTY), all `out_*`=0, `pc_src`=0, `pc_target`=0.
- Latency: entry pushed at edge N appears on `out_*` after edge N when the buffer was EMPTY, or after the preceding entry pops.
- Throughput: one entry per cycle with `out_ready` held high.
- `pc_src` high exactly one cycle, the cycle after the accepting edge; `pc_target` holds its value until the next taken branch or reset.
- Reset or flush asserted mid-burst: outputs zero the cycle after the edge; no partial entry survives.

## Configuration
- `EX_MEM_FWD_EN`: when defined, adds outputs `fwd_valid` (1), `fwd_reg` (REG_W), `fwd_data` (WIDTH) = head entry's `out_valid && out_reg_write && out_dest_reg!=0`, `out_dest_reg`, `out_result`, for EX-stage operand bypass. Not defined: ports absent, no forwarding logic.

## Test plan
- Reset, then push `alu_out`=0x0000_0005, `dest_reg`=3, `reg_write`=1 with `out_ready`=1 → next cycle `out_valid`=1, `out_result`=0x5, `out_dest_reg`=3; following idle cycle `out_valid`=0.
- Hold `out_ready`=0, push A=0x11, B=0x22 → `in_ready`=0 after second push; raise `out_ready` → outputs 0x11 then 0x22 on consecutive cycles, `in_ready` back to 1.
- Push `branch_eq`=1, `alu_zero`=1, `branch_target`=0x0000_0040 → `pc_src`=1 for exactly one cycle with `pc_target`=0x40; repeat with `alu_zero`=0 → `pc_src` stays 0; `branch_ne`=1, `alu_zero`=0 → taken.
- Buffer in TWO, assert `flush` together with `in_valid` and a taken beq → next cycle `out_valid`=0, `in_ready`=1, `pc_src`=0.
- Stream 8 back-to-back entries 0x1..0x8 with `out_ready` toggling every cycle → all 8 delivered in order, none duplicated or lost.
- `EX_MEM_FWD_EN` defined: head entry `dest_reg`=0, `reg_write`=1 → `fwd_valid`=0; `dest_reg`=7 → `fwd_valid`=1, `fwd_data`=`out_result`.
